// File: rtl/alu_mc.sv
// Multi-cycle RV32I-style integer ALU with valid/ready handshakes.
// Non-shift ops complete at the accept edge; shifts run on an iterative
// shifter moving at most SHIFT_STEP bits per cycle.
module alu_mc #(
  parameter int WIDTH      = 32,
  parameter int SHIFT_STEP = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       control,
  input  logic [WIDTH-1:0] input1,
  input  logic [WIDTH-1:0] input2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             illegal
);

  localparam int SW = $clog2(WIDTH);
  // One extra bit so that SHIFT_STEP == WIDTH is representable.
  localparam int CW = SW + 1;
  localparam logic [CW-1:0] STEP_C = CW'(SHIFT_STEP);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             illegal_q, illegal_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    rem_q, rem_d;
  logic [1:0]       shop_q, shop_d;   // 00 sll, 01 srl, 10 sra

  logic [WIDTH-1:0] alu_res;
  logic             alu_ill;
  logic             is_shift;
  logic [SW-1:0]    shamt;
  logic [CW-1:0]    step_amt;
  logic [WIDTH-1:0] shifted;

  assign shamt = input2[SW-1:0];

  // Single-cycle datapath for the non-shift ops and illegal decode.
  always_comb begin
    alu_res  = '0;
    alu_ill  = 1'b0;
    is_shift = 1'b0;
    case (control)
      4'b0000: alu_res = input1 + input2;
      4'b0001: alu_res = input1 - input2;
      4'b0010: alu_res = input1 | input2;
      4'b0011: alu_res = input1 ^ input2;
      4'b0100: alu_res = {{(WIDTH-1){1'b0}}, ($signed(input1) < $signed(input2))};
      4'b0101: alu_res = {{(WIDTH-1){1'b0}}, (input1 < input2)};
      4'b0111: alu_res = input1 & input2;
      4'b1000, 4'b1001, 4'b1010: is_shift = 1'b1;
      default: alu_ill = 1'b1;
    endcase
  end

  // One step of the iterative shifter: min(SHIFT_STEP, remaining) bits.
  always_comb begin
    step_amt = (rem_q < STEP_C) ? rem_q : STEP_C;
    case (shop_q)
      2'b00:   shifted = shreg_q << step_amt;
      2'b01:   shifted = shreg_q >> step_amt;
      default: shifted = $signed(shreg_q) >>> step_amt;
    endcase
  end

  // Next-state and datapath register updates.
  always_comb begin
    state_d   = state_q;
    result_d  = result_q;
    zero_d    = zero_q;
    illegal_d = illegal_q;
    shreg_d   = shreg_q;
    rem_d     = rem_q;
    shop_d    = shop_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (is_shift && (shamt != '0)) begin
            state_d = SHIFT;
            shreg_d = input1;
            rem_d   = CW'(shamt);
            shop_d  = control[1:0];
          end else begin
            // A zero-distance shift simply passes operand A through.
            state_d   = DONE;
            result_d  = is_shift ? input1 : alu_res;
            zero_d    = is_shift ? (input1 == '0) : (alu_res == '0);
            illegal_d = alu_ill;
          end
        end
      end
      SHIFT: begin
        if (rem_q != '0) begin
          shreg_d = shifted;
          rem_d   = rem_q - step_amt;
        end else begin
          state_d   = DONE;
          result_d  = shreg_q;
          zero_d    = (shreg_q == '0);
          illegal_d = 1'b0;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      result_q  <= '0;
      zero_q    <= 1'b0;
      illegal_q <= 1'b0;
      shreg_q   <= '0;
      rem_q     <= '0;
      shop_q    <= 2'b00;
    end else begin
      state_q   <= state_d;
      result_q  <= result_d;
      zero_q    <= zero_d;
      illegal_q <= illegal_d;
      shreg_q   <= shreg_d;
      rem_q     <= rem_d;
      shop_q    <= shop_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = result_q;
  assign zero      = zero_q;
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_alu_mc.sv
// Directed bench for alu_mc: two instances (SHIFT_STEP=1 and 4) share inputs.
module tb_alu_mc;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [3:0]  control;
  logic [31:0] input1, input2;
  logic        out_ready;

  logic        in_ready1, out_valid1, zero1, illegal1;
  logic [31:0] result1;
  logic        in_ready4, out_valid4, zero4, illegal4;
  logic [31:0] result4;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  alu_mc #(.WIDTH(32), .SHIFT_STEP(1)) u1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
    .control(control), .input1(input1), .input2(input2),
    .out_valid(out_valid1), .out_ready(out_ready), .result(result1),
    .zero(zero1), .illegal(illegal1)
  );

  alu_mc #(.WIDTH(32), .SHIFT_STEP(4)) u4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4),
    .control(control), .input1(input1), .input2(input2),
    .out_valid(out_valid4), .out_ready(out_ready), .result(result4),
    .zero(zero4), .illegal(illegal4)
  );

  typedef struct {
    string       name;
    logic [3:0]  ctrl;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        z;
    logic        ill;
    int          lat1;   // clock edges after the accept edge until out_valid (STEP=1)
    int          lat4;   // same for STEP=4
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%h required=%h", nm, act, exp);
  endtask

  task automatic add_vec(input string nm, input logic [3:0] c, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] r, input logic z,
                         input logic il, input int l1, input int l4);
    vec_t v;
    v.name = nm; v.ctrl = c; v.a = a; v.b = b; v.res = r;
    v.z = z; v.ill = il; v.lat1 = l1; v.lat4 = l4;
    vecs.push_back(v);
  endtask

  // Issue one op with out_ready=1 and check both instances' latency and outputs.
  task automatic run_op(input vec_t v);
    int  k;
    int  got1, got4;
    bit  busy_bad;
    logic [31:0] r1, r4;
    logic z1, z4, i1, i4;
    got1 = -1; got4 = -1; busy_bad = 0;
    r1 = 'x; r4 = 'x; z1 = 'x; z4 = 'x; i1 = 'x; i4 = 'x;
    @(negedge clk);
    control = v.ctrl; input1 = v.a; input2 = v.b;
    in_valid = 1'b1; out_ready = 1'b1;
    chk({v.name, " in_ready before accept"}, {30'd0, in_ready1, in_ready4}, 32'd3);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    input1 = $urandom; input2 = $urandom;   // must not affect the op in flight
    k = 0;
    while (k <= 40 && (got1 < 0 || got4 < 0)) begin
      if (got1 < 0) begin
        if (out_valid1) begin got1 = k; r1 = result1; z1 = zero1; i1 = illegal1; end
        else if (in_ready1) busy_bad = 1;
      end
      if (got4 < 0) begin
        if (out_valid4) begin got4 = k; r4 = result4; z4 = zero4; i4 = illegal4; end
        else if (in_ready4) busy_bad = 1;
      end
      if (got1 < 0 || got4 < 0) begin
        @(negedge clk);
        k++;
      end
    end
    chk({v.name, " latency s1"}, got1, v.lat1);
    chk({v.name, " latency s4"}, got4, v.lat4);
    chk({v.name, " result s1"}, r1, v.res);
    chk({v.name, " result s4"}, r4, v.res);
    chk({v.name, " zero/illegal"}, {28'd0, z1, i1, z4, i4}, {28'd0, v.z, v.ill, v.z, v.ill});
    chk({v.name, " in_ready low while busy"}, {31'd0, busy_bad}, 32'd0);
    $display("op %s ctrl=%b a=%h b=%h -> s1 res=%h lat=%0d | s4 res=%h lat=%0d",
             v.name, v.ctrl, v.a, v.b, r1, got1, r4, got4);
  endtask

  initial begin
    vec_t v;
    bit   bad;
    int   stray;

    rst = 1'b1; in_valid = 1'b0; control = 4'd0; input1 = '0; input2 = '0; out_ready = 1'b0;

    add_vec("add_ovf",   4'b0000, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 0, 0, 0, 0);
    add_vec("sub_eq",    4'b0001, 32'd5,        32'd5,        32'h00000000, 1, 0, 0, 0);
    add_vec("slt_neg",   4'b0100, 32'h80000000, 32'h00000000, 32'h00000001, 0, 0, 0, 0);
    add_vec("sltu_big",  4'b0101, 32'h80000000, 32'h00000000, 32'h00000000, 1, 0, 0, 0);
    add_vec("sub_wrap",  4'b0001, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 0, 0, 0, 0);
    add_vec("and",       4'b0111, 32'h0000F0F0, 32'h0000FF00, 32'h0000F000, 0, 0, 0, 0);
    add_vec("or",        4'b0010, 32'h000000F0, 32'h0000000F, 32'h000000FF, 0, 0, 0, 0);
    add_vec("illegal_f", 4'b1111, 32'h12345678, 32'h9ABCDEF0, 32'h00000000, 1, 1, 0, 0);
    add_vec("xor_after", 4'b0011, 32'h000000AA, 32'h000000FF, 32'h00000055, 0, 0, 0, 0);
    add_vec("illegal_6", 4'b0110, 32'h00000001, 32'h00000001, 32'h00000000, 1, 1, 0, 0);
    add_vec("sra_31",    4'b1010, 32'h80000000, 32'd31,       32'hFFFFFFFF, 0, 0, 32, 9);
    add_vec("sll_13",    4'b1000, 32'h00000001, 32'd13,       32'h00002000, 0, 0, 14, 5);
    add_vec("srl_hibits",4'b1001, 32'h80000000, 32'hFFFFFFFF, 32'h00000001, 0, 0, 32, 9);
    add_vec("sll_zero",  4'b1000, 32'h00000005, 32'h00000100, 32'h00000005, 0, 0, 0, 0);
    add_vec("srl_4",     4'b1001, 32'h000000F0, 32'd4,        32'h0000000F, 0, 0, 5, 2);
    add_vec("sra_pos30", 4'b1010, 32'h7FFFFFFF, 32'd30,       32'h00000001, 0, 0, 31, 9);

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("reset in_ready/out_valid", {28'd0, in_ready1, out_valid1, in_ready4, out_valid4}, 32'b1010);
    chk("reset result", result1 | result4, 32'd0);
    chk("reset zero/illegal", {28'd0, zero1, illegal1, zero4, illegal4}, 32'd0);
    $display("reset released");

    foreach (vecs[i]) run_op(vecs[i]);

    // Backpressure: result held while out_ready=0, in_valid pulses ignored.
    @(negedge clk);
    control = 4'b0010; input1 = 32'hF0; input2 = 32'h0F; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (!(out_valid1 && out_valid4 && !in_ready1 && !in_ready4 &&
            result1 == 32'hFF && result4 == 32'hFF && !zero1 && !zero4 &&
            !illegal1 && !illegal4)) bad = 1;
      in_valid = i[0];
      control = 4'b0000; input1 = $urandom; input2 = $urandom;
    end
    chk("backpressure hold", {31'd0, bad}, 32'd0);
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("backpressure release", {28'd0, out_valid1, in_ready1, out_valid4, in_ready4}, 32'b0101);
    chk("backpressure result kept", result1, 32'hFF);
    $display("op backpressure or F0|0F held 6 cycles, released");

    // Reset in the middle of a long shift.
    @(negedge clk);
    control = 4'b1001; input1 = 32'hFFFF0000; input2 = 32'd20; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    chk("mid-shift busy", {31'd0, in_ready1}, 32'd0);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("abort state", {28'd0, in_ready1, out_valid1, in_ready4, out_valid4}, 32'b1010);
    chk("abort result", result1 | result4, 32'd0);
    chk("abort zero/illegal", {28'd0, zero1, illegal1, zero4, illegal4}, 32'd0);
    stray = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (out_valid1 || out_valid4) stray++;
    end
    chk("no stale result after abort", stray, 0);
    $display("op reset mid-shift srl by 20 aborted");

    v.name = "add_after_abort"; v.ctrl = 4'b0000; v.a = 32'd2; v.b = 32'd3;
    v.res = 32'd5; v.z = 0; v.ill = 0; v.lat1 = 0; v.lat4 = 0;
    run_op(v);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/alu_mc.md
Name: alu_mc

Overview:
- Parametrised multi-cycle successor to the single-cycle execute ALU.
- Adds the full RV32I integer op set: add, sub, and, or, xor, slt, sltu, sll, srl, sra.
- Shifts run on an iterative shifter of configurable step width; all other ops take one cycle.
- Sits between decode and writeback, with valid/ready handshakes on input and output and a registered result.

Parameters:
- WIDTH, 32: operand and result width in bits; power of two, at least 8.
- SHIFT_STEP, 1: maximum bits shifted per cycle; power of two in 1..WIDTH. SHIFT_STEP=WIDTH gives single-cycle shifts.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operation request.
- in_ready  out  1  block can accept a request.
- control  in  4  operation select.
- input1  in  WIDTH  operand A.
- input2  in  WIDTH  operand B; shift amount is input2[$clog2(WIDTH)-1:0].
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes the result.
- result  out  WIDTH  registered result.
- zero  out  1  result == 0, registered with result.
- illegal  out  1  control was an unsupported encoding.

Behaviour:
- Clock and reset: one clock `clk`; `rst` is synchronous and active-high. No other clock or async path.
- Control encoding:
  - 0000 add, 0001 sub, 0010 or, 0011 xor, 0100 slt (signed), 0101 sltu, 0111 and.
  - 1000 sll, 1001 srl, 1010 sra.
  - All other codes are illegal.
- Arithmetic: add and sub wrap modulo 2^WIDTH, with no carry or overflow output. slt and sltu give a result of 1 or 0, zero-extended. sra replicates input1's MSB.
- States: IDLE, SHIFT, DONE.
- Reset (rst=1 at a clock edge):
  - state=IDLE, out_valid=0, result=0, zero=0, illegal=0, internal shift counter=0.
  - Reset wins over every other event and aborts any operation in flight, with no output produced.
- in_ready = (state==IDLE). It is combinational from state only and never depends on in_valid.
- Accept happens at a clock edge with in_valid && in_ready. control and operands are captured at that edge only.
- Non-shift op, or shift with shamt=0:
  - result, zero and illegal are written at the accept edge, and state goes to DONE.
  - out_valid=1 in the cycle after the accept edge (latency 1).
- Shift with shamt s>0:
  - State goes to SHIFT at accept; the operand loads into the shift register and the remaining count is set to s.
  - Each SHIFT cycle shifts by min(SHIFT_STEP, remaining) and decrements remaining.
  - When remaining reaches 0, the next edge writes result and zero and enters DONE.
  - out_valid rises 1+ceil(s/SHIFT_STEP) cycles after the accept edge.
- Illegal op: result=0, zero=1, illegal=1, with the same latency as a non-shift op. No simulation message is required.
- DONE state:
  - out_valid=1; result, zero and illegal are held stable until out_ready=1 at an edge.
  - At that edge the block returns to IDLE and out_valid=0.
  - A new request is not accepted in the same edge, so back-to-back throughput is 1 op per 2 cycles minimum.
- Inputs are ignored outside the accept edge. Changing operands while busy has no effect.
- out_ready while out_valid=0 is ignored.
- Boundary cases:
  - Shift amount WIDTH-1 is the maximum.
  - Upper bits of input2 above the shamt field are ignored for shifts.
  - sub of 0 - 1 gives all-ones.
  - slt of most-negative vs 0 gives 1.
- out_valid, result and zero change only at clock edges; there are no combinational paths from inputs to outputs except in_ready.

Test Plan:
- Reset, then add 0x7FFFFFFF+1 and out_ready=1 → in_ready=1 before accept; one cycle later out_valid=1, result=0x80000000, zero=0; IDLE the next cycle.
- sub 5-5, then slt 0x80000000 vs 0, then sltu 0x80000000 vs 0, out_ready=1 → results 0 (zero=1), 1, 0.
- SHIFT_STEP=1: sra 0x80000000 by 31 → out_valid exactly 32 cycles after accept, result=0xFFFFFFFF, in_ready=0 throughout. SHIFT_STEP=4: sll 1 by 13 → 5 cycles, result=0x2000.
- Backpressure: or 0xF0|0x0F with out_ready=0 for 6 cycles → result=0xFF held stable, out_valid=1, in_ready=0; in_valid pulses are ignored; release drops out_valid the next edge.
- Illegal control 1111 → result=0, zero=1, illegal=1 at latency 1; the next legal xor 0xAA^0xFF clears illegal and gives result 0x55.
- Assert rst mid-shift (srl by 20, 10 cycles in) → the next cycle shows IDLE, out_valid=0, result=0, and no stale result ever appears; a fresh add 2+3 then returns 5.
